// File: rtl/ahb_lite_master_port.sv
// AHB-Lite single-transfer master port: turns a valid/ready command stream into
// pipelined AHB address/data phases and returns one in-order response per command.
module ahb_lite_master_port (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [2:0]  CMD_SIZE,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            3'b000:  mis = 1'b0;
            3'b001:  mis = addr_lo[0];
            3'b010:  mis = (addr_lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    logic        accept_s;
    logic        mis_s;
    logic        ap_valid_r;
    logic        ap_mis_r;
    logic [31:0] ap_wdata_r;
    logic        dp_valid_r;
    logic        dp_write_r;
    logic        dp_mis_r;

    assign CMD_READY = HREADY & ~HRESET;

    // Command acceptance and alignment classification.
    always_comb begin
        accept_s = 1'b0;
        mis_s    = 1'b0;
        if (CMD_VALID && CMD_READY) begin
            accept_s = 1'b1;
            mis_s    = is_misaligned(CMD_SIZE, CMD_ADDR[1:0]);
        end else begin
            accept_s = 1'b0;
            mis_s    = 1'b0;
        end
    end

    // Address/data pipeline; everything freezes while HREADY is low.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HADDR      <= 32'h0000_0000;
            HBURST     <= 3'b000;
            HSIZE      <= 3'b010;
            HTRANS     <= HTRANS_IDLE;
            HWDATA     <= 32'h0000_0000;
            HWRITE     <= 1'b0;
            ap_valid_r <= 1'b0;
            ap_mis_r   <= 1'b0;
            ap_wdata_r <= 32'h0000_0000;
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_mis_r   <= 1'b0;
        end else if (HREADY) begin
            HBURST     <= 3'b000;
            dp_valid_r <= ap_valid_r;
            dp_write_r <= HWRITE;
            dp_mis_r   <= ap_mis_r;
            // Write data follows its command into the data phase; misaligned slots never drive the bus.
            if (ap_valid_r && HWRITE && !ap_mis_r) begin
                HWDATA <= ap_wdata_r;
            end else begin
                HWDATA <= HWDATA;
            end
            if (accept_s) begin
                ap_valid_r <= 1'b1;
                ap_mis_r   <= mis_s;
                ap_wdata_r <= CMD_WDATA;
                HADDR      <= CMD_ADDR;
                HWRITE     <= CMD_WRITE;
                HSIZE      <= CMD_SIZE;
                HTRANS     <= mis_s ? HTRANS_IDLE : HTRANS_NONSEQ;
            end else begin
                ap_valid_r <= 1'b0;
                ap_mis_r   <= 1'b0;
                HTRANS     <= HTRANS_IDLE;
            end
        end else begin
            HBURST <= 3'b000;
        end
    end

    // One-cycle response pulse when an occupied data-phase slot completes.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 32'h0000_0000;
            RSP_ERR   <= 1'b0;
        end else if (HREADY && dp_valid_r) begin
            RSP_VALID <= 1'b1;
            RSP_ERR   <= dp_mis_r | HRESP;
            RSP_RDATA <= (dp_write_r || dp_mis_r) ? 32'h0000_0000 : HRDATA;
        end else begin
            RSP_VALID <= 1'b0;
            RSP_RDATA <= 32'h0000_0000;
            RSP_ERR   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Self-checking bench for ahb_lite_master_port: directed protocol scenarios plus
// a randomized run against a command-queue reference model.
module tb_ahb_lite_master_port;

    logic        HCLK, HRESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic [2:0]  CMD_SIZE;
    logic        RSP_VALID, RSP_ERR;
    logic [31:0] RSP_RDATA;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HBURST, HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        mis;
    } cmd_t;

    ahb_lite_master_port dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .HADDR(HADDR), .HBURST(HBURST), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1; CMD_VALID = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_SIZE = sz; CMD_WDATA = wd;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0; CMD_ADDR = 32'h0; CMD_SIZE = 3'b010; CMD_WDATA = 32'h0; HRDATA = 32'h0;
        @(posedge HCLK); #1;
        vec_cnt++; if (HTRANS !== 2'b00) begin err_cnt++; $display("FAIL rst_htrans: got %h want 0", HTRANS); end
        vec_cnt++; if (HADDR !== 32'h0) begin err_cnt++; $display("FAIL rst_haddr: got %h want 0", HADDR); end
        vec_cnt++; if (HWRITE !== 1'b0) begin err_cnt++; $display("FAIL rst_hwrite: got %b want 0", HWRITE); end
        vec_cnt++; if (HSIZE !== 3'b010) begin err_cnt++; $display("FAIL rst_hsize: got %b want 010", HSIZE); end
        vec_cnt++; if (HBURST !== 3'b000) begin err_cnt++; $display("FAIL rst_hburst: got %b want 000", HBURST); end
        vec_cnt++; if (HWDATA !== 32'h0) begin err_cnt++; $display("FAIL rst_hwdata: got %h want 0", HWDATA); end
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0", RSP_VALID); end
        vec_cnt++; if (RSP_RDATA !== 32'h0) begin err_cnt++; $display("FAIL rst_rsp_rdata: got %h want 0", RSP_RDATA); end
        vec_cnt++; if (RSP_ERR !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_err: got %b want 0", RSP_ERR); end
        vec_cnt++; if (CMD_READY !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_ready: got %b want 0", CMD_READY); end
        HRESET = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_cmd(1'b0, 32'h0000_0010, 3'b010, 32'h0);
        #1;
        vec_cnt++; if (CMD_READY !== 1'b1) begin err_cnt++; $display("FAIL sr_ready: got %b want 1", CMD_READY); end
        tick();
        CMD_VALID = 1'b0; HRDATA = 32'hDEAD_BEEF;
        vec_cnt++; if (HTRANS !== 2'b10) begin err_cnt++; $display("FAIL sr_nonseq: got %h want 2", HTRANS); end
        vec_cnt++; if (HADDR !== 32'h10) begin err_cnt++; $display("FAIL sr_haddr: got %h want 10", HADDR); end
        vec_cnt++; if (HWRITE !== 1'b0) begin err_cnt++; $display("FAIL sr_hwrite: got %b want 0", HWRITE); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL sr_early_rsp: got %b want 0", RSP_VALID); end
        vec_cnt++; if (HTRANS !== 2'b00) begin err_cnt++; $display("FAIL sr_idle: got %h want 0", HTRANS); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b1) begin err_cnt++; $display("FAIL sr_rsp_valid: got %b want 1", RSP_VALID); end
        vec_cnt++; if (RSP_RDATA !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL sr_rdata: got %h want deadbeef", RSP_RDATA); end
        vec_cnt++; if (RSP_ERR !== 1'b0) begin err_cnt++; $display("FAIL sr_err: got %b want 0", RSP_ERR); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL sr_pulse: got %b want 0", RSP_VALID); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_cmd(1'b1, 32'h0000_0100, 3'b010, 32'h1234_5678);
        tick();
        set_cmd(1'b0, 32'h0000_0104, 3'b010, 32'h0);
        tick();
        CMD_VALID = 1'b0; HRDATA = 32'hA5A5_0001;
        vec_cnt++; if (HADDR !== 32'h104) begin err_cnt++; $display("FAIL b2b_haddr: got %h want 104", HADDR); end
        vec_cnt++; if (HWDATA !== 32'h1234_5678) begin err_cnt++; $display("FAIL b2b_hwdata: got %h want 12345678", HWDATA); end
        vec_cnt++; if (HTRANS !== 2'b10) begin err_cnt++; $display("FAIL b2b_htrans: got %h want 2", HTRANS); end
        tick();
        HRDATA = 32'hCAFE_F00D;
        vec_cnt++; if (RSP_VALID !== 1'b1) begin err_cnt++; $display("FAIL b2b_rsp1: got %b want 1", RSP_VALID); end
        vec_cnt++; if (RSP_RDATA !== 32'h0) begin err_cnt++; $display("FAIL b2b_wr_rdata: got %h want 0", RSP_RDATA); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b1) begin err_cnt++; $display("FAIL b2b_rsp2: got %b want 1", RSP_VALID); end
        vec_cnt++; if (RSP_RDATA !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL b2b_rd_rdata: got %h want cafef00d", RSP_RDATA); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL b2b_end: got %b want 0", RSP_VALID); end
    endtask

    task automatic test_wait_states();
        do_reset();
        set_cmd(1'b0, 32'h0000_0200, 3'b010, 32'h0);
        tick();
        set_cmd(1'b0, 32'h0000_0204, 3'b010, 32'h0);
        tick();
        CMD_VALID = 1'b0; HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec_cnt++; if (CMD_READY !== 1'b0) begin err_cnt++; $display("FAIL ws_ready[%0d]: got %b want 0", i, CMD_READY); end
            tick();
            vec_cnt++; if (HADDR !== 32'h204) begin err_cnt++; $display("FAIL ws_haddr[%0d]: got %h want 204", i, HADDR); end
            vec_cnt++; if (HTRANS !== 2'b10) begin err_cnt++; $display("FAIL ws_htrans[%0d]: got %h want 2", i, HTRANS); end
            vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL ws_rsp[%0d]: got %b want 0", i, RSP_VALID); end
        end
        HREADY = 1'b1; HRDATA = 32'h1111_2222;
        tick();
        HRDATA = 32'h3333_4444;
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h1111_2222) begin err_cnt++; $display("FAIL ws_rsp1: got %b/%h want 1/11112222", RSP_VALID, RSP_RDATA); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h3333_4444) begin err_cnt++; $display("FAIL ws_rsp2: got %b/%h want 1/33334444", RSP_VALID, RSP_RDATA); end
    endtask

    task automatic test_error();
        do_reset();
        set_cmd(1'b1, 32'hFFFF_0000, 3'b010, 32'h0BAD_0BAD);
        tick();
        set_cmd(1'b0, 32'h0000_0300, 3'b010, 32'h0);
        tick();
        CMD_VALID = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
        tick();
        vec_cnt++; if (HTRANS !== 2'b10 || HADDR !== 32'h300) begin err_cnt++; $display("FAIL err_hold: got %h/%h want 2/300", HTRANS, HADDR); end
        vec_cnt++; if (HWDATA !== 32'h0BAD_0BAD) begin err_cnt++; $display("FAIL err_hwdata: got %h want 0bad0bad", HWDATA); end
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL err_early: got %b want 0", RSP_VALID); end
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0; HRDATA = 32'h5555_AAAA;
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1) begin err_cnt++; $display("FAIL err_rsp: got %b/%b want 1/1", RSP_VALID, RSP_ERR); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'h5555_AAAA) begin err_cnt++; $display("FAIL err_next: got %b/%b/%h want 1/0/5555aaaa", RSP_VALID, RSP_ERR, RSP_RDATA); end
    endtask

    task automatic test_misaligned();
        do_reset();
        set_cmd(1'b0, 32'h0000_0010, 3'b010, 32'h0);
        tick();
        set_cmd(1'b0, 32'h0000_0002, 3'b010, 32'h0);
        tick();
        vec_cnt++; if (HTRANS !== 2'b00) begin err_cnt++; $display("FAIL mis_idle: got %h want 0", HTRANS); end
        set_cmd(1'b0, 32'h0000_0020, 3'b010, 32'h0);
        HRDATA = 32'h0101_0101;
        tick();
        CMD_VALID = 1'b0;
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'h0101_0101) begin err_cnt++; $display("FAIL mis_first: got %b/%b/%h want 1/0/01010101", RSP_VALID, RSP_ERR, RSP_RDATA); end
        vec_cnt++; if (HTRANS !== 2'b10 || HADDR !== 32'h20) begin err_cnt++; $display("FAIL mis_third_ap: got %h/%h want 2/20", HTRANS, HADDR); end
        tick();
        HRDATA = 32'h0202_0202;
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1) begin err_cnt++; $display("FAIL mis_err: got %b/%b want 1/1", RSP_VALID, RSP_ERR); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'h0202_0202) begin err_cnt++; $display("FAIL mis_third: got %b/%b/%h want 1/0/02020202", RSP_VALID, RSP_ERR, RSP_RDATA); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_cmd(1'b1, 32'h0000_0400, 3'b010, 32'h7777_8888);
        tick();
        CMD_VALID = 1'b0;
        tick();
        #2 HRESET = 1'b1;
        #1;
        vec_cnt++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b010 || HWDATA !== 32'h0)
            begin err_cnt++; $display("FAIL mid_bus: got %h/%h/%b/%b/%h want 0/0/0/010/0", HTRANS, HADDR, HWRITE, HSIZE, HWDATA); end
        vec_cnt++; if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b0) begin err_cnt++; $display("FAIL mid_rsp: got %b/%b want 0/0", RSP_VALID, CMD_READY); end
        @(posedge HCLK);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        set_cmd(1'b0, 32'h0000_0040, 3'b010, 32'h0);
        HRDATA = 32'h9999_0000;
        tick();
        CMD_VALID = 1'b0;
        vec_cnt++; if (HTRANS !== 2'b10 || HADDR !== 32'h40) begin err_cnt++; $display("FAIL mid_first_accept: got %h/%h want 2/40", HTRANS, HADDR); end
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL mid_lost0: got %b want 0", RSP_VALID); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b0) begin err_cnt++; $display("FAIL mid_lost1: got %b want 0", RSP_VALID); end
        tick();
        vec_cnt++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h9999_0000) begin err_cnt++; $display("FAIL mid_new_rsp: got %b/%h want 1/99990000", RSP_VALID, RSP_RDATA); end
    endtask

    task automatic test_random();
        cmd_t        q[$];
        cmd_t        c;
        logic        front_dp, e_rsp_v, e_rsp_e;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr, e_hwdata, e_rsp_d;
        logic [2:0]  e_hsize;
        logic        e_hwrite;
        do_reset();
        front_dp = 1'b0; e_rsp_v = 1'b0; e_rsp_e = 1'b0; e_rsp_d = 32'h0;
        e_htrans = 2'b00; e_haddr = 32'h0; e_hwdata = 32'h0; e_hsize = 3'b010; e_hwrite = 1'b0;
        for (int i = 0; i < 400; i++) begin
            CMD_VALID = ($urandom_range(0, 3) != 0);
            CMD_WRITE = 1'($urandom_range(0, 1));
            CMD_SIZE  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            CMD_ADDR  = $urandom;
            if ($urandom_range(0, 1) == 1) CMD_ADDR[1:0] = 2'b00;
            CMD_WDATA = $urandom;
            HREADY    = ($urandom_range(0, 3) != 0);
            HRESP     = ($urandom_range(0, 5) == 0);
            HRDATA    = $urandom;
            #1;
            vec_cnt++; if (CMD_READY !== HREADY) begin err_cnt++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, CMD_READY, HREADY); end
            if (HREADY) begin
                e_rsp_v = 1'b0; e_rsp_e = 1'b0; e_rsp_d = 32'h0;
                if (front_dp) begin
                    c = q.pop_front();
                    e_rsp_v = 1'b1;
                    e_rsp_e = c.mis ? 1'b1 : HRESP;
                    e_rsp_d = (c.mis || c.w) ? 32'h0 : HRDATA;
                end
                front_dp = (q.size() != 0);
                if (front_dp && q[0].w && !q[0].mis) e_hwdata = q[0].wd;
                if (CMD_VALID) begin
                    c.w = CMD_WRITE; c.a = CMD_ADDR; c.sz = CMD_SIZE; c.wd = CMD_WDATA;
                    c.mis = (CMD_SIZE == 3'd1 && CMD_ADDR[0]) || (CMD_SIZE == 3'd2 && CMD_ADDR[1:0] != 2'b00) || (CMD_SIZE >= 3'd3);
                    q.push_back(c);
                    e_htrans = c.mis ? 2'b00 : 2'b10;
                    e_haddr = CMD_ADDR; e_hwrite = CMD_WRITE; e_hsize = CMD_SIZE;
                end else begin
                    e_htrans = 2'b00;
                end
            end else begin
                e_rsp_v = 1'b0;
            end
            tick();
            vec_cnt++; if (HTRANS !== e_htrans) begin err_cnt++; $display("FAIL rnd_htrans[%0d]: got %h want %h", i, HTRANS, e_htrans); end
            if (e_htrans == 2'b10) begin
                vec_cnt++; if (HADDR !== e_haddr || HWRITE !== e_hwrite || HSIZE !== e_hsize)
                    begin err_cnt++; $display("FAIL rnd_addr[%0d]: got %h/%b/%b want %h/%b/%b", i, HADDR, HWRITE, HSIZE, e_haddr, e_hwrite, e_hsize); end
            end
            if (front_dp && q[0].w && !q[0].mis) begin
                vec_cnt++; if (HWDATA !== e_hwdata) begin err_cnt++; $display("FAIL rnd_hwdata[%0d]: got %h want %h", i, HWDATA, e_hwdata); end
            end
            vec_cnt++; if (RSP_VALID !== e_rsp_v) begin err_cnt++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", i, RSP_VALID, e_rsp_v); end
            if (e_rsp_v) begin
                vec_cnt++; if (RSP_RDATA !== e_rsp_d || RSP_ERR !== e_rsp_e)
                    begin err_cnt++; $display("FAIL rnd_rsp[%0d]: got %h/%b want %h/%b", i, RSP_RDATA, RSP_ERR, e_rsp_d, e_rsp_e); end
            end
            vec_cnt++; if (HBURST !== 3'b000) begin err_cnt++; $display("FAIL rnd_hburst[%0d]: got %b want 000", i, HBURST); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master_port.md
AHB_LITE_MASTER_PORT -- requirements
Module: ahb_lite_master_port

Interface
REQ-001 SHALL have port HCLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port HRESET, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port CMD_VALID, input, 1 bit: request present.
REQ-004 SHALL have port CMD_READY, output, 1 bit: request accepted when CMD_VALID and CMD_READY are both high at a clock edge.
REQ-005 SHALL have port CMD_WRITE, input, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have port CMD_ADDR, input, 32 bits: byte address.
REQ-007 SHALL have port CMD_SIZE, input, 3 bits: HSIZE encoding; only 000, 001 and 010 are legal.
REQ-008 SHALL have port CMD_WDATA, input, 32 bits: write data, lane-placed by the requester.
REQ-009 SHALL have port RSP_VALID, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port RSP_RDATA, output, 32 bits: read data.
REQ-011 SHALL have port RSP_ERR, output, 1 bit: error completion.
REQ-012 SHALL have outputs HADDR (32), HBURST (3), HSIZE (3), HTRANS (2), HWDATA (32) and HWRITE (1), and inputs HRDATA (32), HREADY (1) and HRESP (1), all with AHB-Lite meaning.

Function
REQ-013 SHALL drive HBURST=000 (SINGLE) permanently and use HTRANS values IDLE (00) and NONSEQ (10) only.
REQ-014 SHALL register all AHB outputs.
REQ-015 SHALL hold at most one address phase and one data phase outstanding.
REQ-016 SHALL generate CMD_READY = HREADY AND NOT HRESET, combinationally.
REQ-017 SHALL, at an edge with HREADY=1:
- move the address-phase entry to the data phase;
- load an accepted command into the address phase, or drive HTRANS=IDLE if none was accepted.
REQ-018 SHALL, at an edge with HREADY=0, hold HADDR, HTRANS, HWRITE, HSIZE and HWDATA unchanged.
REQ-019 SHALL drive HWDATA from the write command during that command's data phase, for its whole duration.
REQ-020 SHALL mark an accepted command as misaligned when CMD_SIZE=001 and CMD_ADDR[0]=1, when CMD_SIZE=010 and CMD_ADDR[1:0]!=00, or when CMD_SIZE is 011 or greater.
REQ-021 SHALL issue a misaligned command as HTRANS=IDLE, while still occupying its pipeline slot.
REQ-022 SHALL complete a misaligned command with RSP_ERR=1 at the slot's data-phase end, in order.
REQ-023 SHALL raise RSP_VALID for exactly one cycle, in the cycle after the data phase completes (HREADY=1).
REQ-024 SHALL report responses in command order.
REQ-025 SHALL, on a completing read, set RSP_RDATA to the sampled HRDATA; on a completing write, RSP_RDATA=0.
REQ-026 SHALL set RSP_ERR to the HRESP value sampled at completion.
REQ-027 SHALL continue and not cancel the pending address phase when HRESP=1 with HREADY=0, the first error cycle.
REQ-028 SHALL sample HRDATA and HRESP only for an active data phase.
REQ-029 SHALL give a read, with no wait states, acceptance edge at cycle n, address phase at n+1, data phase at n+2, RSP_VALID at n+3.
REQ-030 SHALL sustain back-to-back commands at one per cycle when HREADY=1.
REQ-031 SHALL have no RSP back-pressure; the consumer SHALL always take RSP_VALID.

Reset
REQ-032 SHALL, while HRESET=1, set outputs to:
- HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HBURST=000, HWDATA=0;
- RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0;
- CMD_READY=0.
REQ-033 SHALL, on reset mid-transfer, discard all outstanding entries with no RSP_VALID.
REQ-034 SHALL, after reset, accept its first command at the first edge with HRESET=0 and HREADY=1.

Verification
REQ-035 SHALL pass a single read: read 0x0000_0010, size 010, HRDATA=0xDEAD_BEEF, HREADY=1 -> NONSEQ at n+1, RSP_VALID at n+3 with RSP_RDATA=0xDEAD_BEEF and RSP_ERR=0.
REQ-036 SHALL pass a back-to-back write then read: W 0x100 data 0x1234_5678, then R 0x104 -> HWDATA=0x1234_5678 in the same cycle that HADDR=0x104, and two RSP pulses in consecutive cycles.
REQ-037 SHALL pass a wait-state test: HREADY=0 for 3 cycles during the read data phase -> HADDR and HTRANS held, CMD_READY=0 for 3 cycles, RSP_VALID delayed by 3 cycles.
REQ-038 SHALL pass an error test: two-cycle HRESP=1 response on a write to 0xFFFF_0000 -> RSP_ERR=1 with RSP_VALID, and the following queued read completes normally.
REQ-039 SHALL pass a misaligned test: word read at 0x0000_0002 -> HTRANS stays IDLE, and RSP_VALID with RSP_ERR=1 in its ordered slot.
REQ-040 SHALL pass a reset test: HRESET pulse during a data phase -> all outputs at reset values, and no RSP_VALID for the lost command.
